// File: rtl/hcsr04_measurement_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// hcsr04_measurement_scheduler_pkg
// Shared definitions for the HC-SR04 measurement scheduler: FSM state
// encoding, default timing parameters (50 MHz clock), counter widths and
// saturating increment helpers.
// ----------------------------------------------------------------------------
package hcsr04_measurement_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG      = 3'd1,
      ST_WAIT_ECHO = 3'd2,
      ST_MEASURE   = 3'd3,
      ST_CONVERT   = 3'd4,
      ST_SEND      = 3'd5,
      ST_HOLDOFF   = 3'd6
   } state_e;

   // Defaults for a 50 MHz clock
   localparam int unsigned TRIG_WIDTH_DEF   = 32'd500;        // 10 us
   localparam int unsigned ECHO_TIMEOUT_DEF = 32'd1_900_000;  // 38 ms
   localparam int unsigned CYCLE_PERIOD_DEF = 32'd3_000_000;  // 60 ms
   localparam int unsigned CONV_TIMEOUT_DEF = 32'd1024;

   localparam int unsigned PERIOD_CNT_W = 32'd22;
   localparam int unsigned ECHO_CNT_W   = 32'd21;

   // Saturating increment for the 22-bit period counter
   function automatic logic [PERIOD_CNT_W-1:0] sat_inc_period(input logic [PERIOD_CNT_W-1:0] v);
      return (v == {PERIOD_CNT_W{1'b1}}) ? v : v + 22'd1;
   endfunction

   // Saturating increment for the 21-bit echo counter
   function automatic logic [ECHO_CNT_W-1:0] sat_inc_echo(input logic [ECHO_CNT_W-1:0] v);
      return (v == {ECHO_CNT_W{1'b1}}) ? v : v + 21'd1;
   endfunction

endpackage

// File: rtl/hcsr04_measurement_scheduler_echo_sync.sv
// ----------------------------------------------------------------------------
// hcsr04_echo_sync
// Two-flop synchronizer for the raw HC-SR04 echo plus registered rise/fall
// pulses. Echo_sync_o is delayed so that it lines up with Rise_o / Fall_o:
// in the cycle Rise_o is high Echo_sync_o is already high, in the cycle
// Fall_o is high Echo_sync_o is already low.
//   Clk_i       system clock
//   Reset_i     asynchronous active-low reset
//   Echo_i      raw echo, asynchronous to Clk_i
//   Echo_sync_o synchronized echo level
//   Rise_o      one-clock pulse on synchronized rising edge
//   Fall_o      one-clock pulse on synchronized falling edge
// ----------------------------------------------------------------------------
module hcsr04_echo_sync (
   input  logic Clk_i,
   input  logic Reset_i,
   input  logic Echo_i,
   output logic Echo_sync_o,
   output logic Rise_o,
   output logic Fall_o
);

   logic meta_r;
   logic sync_r;
   logic dly_r;
   logic rise_r;
   logic fall_r;

   // Synchronizer chain and edge detection on the synchronized level
   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
         dly_r  <= 1'b0;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         meta_r <= Echo_i;
         sync_r <= meta_r;
         dly_r  <= sync_r;
         rise_r <= sync_r & ~dly_r;
         fall_r <= ~sync_r & dly_r;
      end
   end

   assign Echo_sync_o = dly_r;
   assign Rise_o      = rise_r;
   assign Fall_o      = fall_r;

endmodule

// File: rtl/hcsr04_measurement_scheduler.sv
// ----------------------------------------------------------------------------
// hcsr04_measurement_scheduler
// Sequences HC-SR04 ranging: trigger pulse, echo wait and width measurement,
// hand-off to a distance-to-BCD converter and then to a UART transmitter,
// followed by a hold-off that enforces the minimum trigger-to-trigger period.
//   Clk_i            system clock
//   Reset_i          asynchronous active-low reset
//   Enable_i         continuous ranging while high
//   Single_shot_i    one-clock request for one measurement (IDLE only)
//   Echo_i           raw echo from the sensor
//   Conv_done_i      converter done pulse
//   Uart_busy_i      UART frame in progress
//   Trig_o           sensor trigger
//   Conv_start_o     one-clock converter start
//   Data_available_o one-clock pulse to the UART transmitter
//   Timeout_o        one-clock pulse on echo or conversion timeout
//   Busy_o           high whenever the FSM is not idle
//   Echo_width_o     last valid echo width in clocks
// ----------------------------------------------------------------------------
module hcsr04_measurement_scheduler
   import hcsr04_measurement_scheduler_pkg::*;
#(
   parameter int unsigned trig_width_p   = TRIG_WIDTH_DEF,
   parameter int unsigned echo_timeout_p = ECHO_TIMEOUT_DEF,
   parameter int unsigned cycle_period_p = CYCLE_PERIOD_DEF,
   parameter int unsigned conv_timeout_p = CONV_TIMEOUT_DEF
) (
   input  logic        Clk_i,
   input  logic        Reset_i,
   input  logic        Enable_i,
   input  logic        Single_shot_i,
   input  logic        Echo_i,
   input  logic        Conv_done_i,
   input  logic        Uart_busy_i,
   output logic        Trig_o,
   output logic        Conv_start_o,
   output logic        Data_available_o,
   output logic        Timeout_o,
   output logic        Busy_o,
   output logic [20:0] Echo_width_o
);

   localparam int unsigned CONV_CNT_W = $clog2(conv_timeout_p + 32'd1);

   localparam logic [PERIOD_CNT_W-1:0] TRIG_LAST   = PERIOD_CNT_W'(trig_width_p - 32'd1);
   localparam logic [PERIOD_CNT_W-1:0] PERIOD_LAST = PERIOD_CNT_W'(cycle_period_p - 32'd1);
   localparam logic [ECHO_CNT_W-1:0]   WAIT_LAST   = ECHO_CNT_W'(echo_timeout_p - 32'd1);
   localparam logic [ECHO_CNT_W-1:0]   ECHO_MAX    = ECHO_CNT_W'(echo_timeout_p);
   localparam logic [CONV_CNT_W-1:0]   CONV_LAST   = CONV_CNT_W'(conv_timeout_p - 32'd1);

   state_e                  state_r;
   logic [PERIOD_CNT_W-1:0] period_cnt_r;
   logic [ECHO_CNT_W-1:0]   echo_cnt_r;
   logic [CONV_CNT_W-1:0]   conv_cnt_r;
   logic                    trig_r;
   logic                    conv_start_r;
   logic                    data_avail_r;
   logic                    timeout_r;
   logic                    busy_r;
   logic [ECHO_CNT_W-1:0]   echo_width_r;

   logic echo_lvl_s;
   logic echo_rise_s;
   logic echo_fall_s;

   hcsr04_echo_sync u_echo_sync (
      .Clk_i       (Clk_i),
      .Reset_i     (Reset_i),
      .Echo_i      (Echo_i),
      .Echo_sync_o (echo_lvl_s),
      .Rise_o      (echo_rise_s),
      .Fall_o      (echo_fall_s)
   );

   // Measurement FSM with its counters and registered outputs
   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         state_r      <= ST_IDLE;
         period_cnt_r <= '0;
         echo_cnt_r   <= '0;
         conv_cnt_r   <= '0;
         trig_r       <= 1'b0;
         conv_start_r <= 1'b0;
         data_avail_r <= 1'b0;
         timeout_r    <= 1'b0;
         busy_r       <= 1'b0;
         echo_width_r <= '0;
      end else begin
         conv_start_r <= 1'b0;
         data_avail_r <= 1'b0;
         timeout_r    <= 1'b0;
         // Free-running between TRIG entries; TRIG entry overrides with 0
         period_cnt_r <= sat_inc_period(period_cnt_r);

         case (state_r)
            ST_IDLE: begin
               if (Enable_i || Single_shot_i) begin
                  state_r      <= ST_TRIG;
                  period_cnt_r <= '0;
                  trig_r       <= 1'b1;
                  busy_r       <= 1'b1;
               end
            end

            // The period counter doubles as the trigger-width timer
            ST_TRIG: begin
               if (period_cnt_r == TRIG_LAST) begin
                  state_r    <= ST_WAIT_ECHO;
                  trig_r     <= 1'b0;
                  echo_cnt_r <= '0;
               end
            end

            ST_WAIT_ECHO: begin
               if (echo_rise_s) begin
                  state_r    <= ST_MEASURE;
                  echo_cnt_r <= 21'd1;
               end else if (echo_cnt_r == WAIT_LAST) begin
                  state_r   <= ST_HOLDOFF;
                  timeout_r <= 1'b1;
               end else begin
                  echo_cnt_r <= sat_inc_echo(echo_cnt_r);
               end
            end

            // A falling edge wins over a simultaneous timeout: a width equal
            // to the timeout is still a valid measurement
            ST_MEASURE: begin
               if (echo_fall_s) begin
                  state_r      <= ST_CONVERT;
                  echo_width_r <= echo_cnt_r;
                  conv_start_r <= 1'b1;
                  conv_cnt_r   <= '0;
               end else if (echo_cnt_r >= ECHO_MAX) begin
                  state_r   <= ST_HOLDOFF;
                  timeout_r <= 1'b1;
               end else if (echo_lvl_s) begin
                  echo_cnt_r <= sat_inc_echo(echo_cnt_r);
               end
            end

            ST_CONVERT: begin
               if (Conv_done_i) begin
                  state_r <= ST_SEND;
               end else if (conv_cnt_r == CONV_LAST) begin
                  state_r   <= ST_HOLDOFF;
                  timeout_r <= 1'b1;
               end else begin
                  conv_cnt_r <= conv_cnt_r + 1'b1;
               end
            end

            ST_SEND: begin
               if (!Uart_busy_i) begin
                  state_r      <= ST_HOLDOFF;
                  data_avail_r <= 1'b1;
               end
            end

            ST_HOLDOFF: begin
               if (period_cnt_r >= PERIOD_LAST) begin
                  if (Enable_i) begin
                     state_r      <= ST_TRIG;
                     period_cnt_r <= '0;
                     trig_r       <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end
            end

            default: begin
               state_r      <= ST_IDLE;
               trig_r       <= 1'b0;
               busy_r       <= 1'b0;
               echo_width_r <= '0;
            end
         endcase
      end
   end

   assign Trig_o           = trig_r;
   assign Conv_start_o     = conv_start_r;
   assign Data_available_o = data_avail_r;
   assign Timeout_o        = timeout_r;
   assign Busy_o           = busy_r;
   assign Echo_width_o     = echo_width_r;

endmodule
